// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit restoring divider for DIV/DIVU
//
// One restoring step per cycle on operand magnitudes, then a sign fix-up
// when the result is captured. Holds the EX stage via DIV_STALL_REQ while
// a division is in flight.
//
// Ports:
//   CLK            clock, rising edge
//   RST            synchronous active-high reset
//   START          division requested this cycle
//   ANNUL          abandon the current division
//   SIGNED_DIV     1 = DIV (two's complement), 0 = DIVU
//   OPDATA1        dividend, sampled when leaving IDLE
//   OPDATA2        divisor, sampled when leaving IDLE
//   RESULT         {remainder, quotient}, valid while READY, else 0
//   READY          high exactly while in END
//   DIV_STALL_REQ  stall request to EX (combinational)

module div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ANNUL,
  input  logic        SIGNED_DIV,
  input  logic [31:0] OPDATA1,
  input  logic [31:0] OPDATA2,
  output logic [63:0] RESULT,
  output logic        READY,
  output logic        DIV_STALL_REQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BY_ZERO,
    S_ON,
    S_END
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  // Low 64 bits of the 65-bit working register; bit 64 is only ever
  // needed from the post-step value at capture time, so it is not stored.
  logic [63:0] dreg;
  logic [31:0] vreg;
  logic        sign1;
  logic        sign2;
  logic        signed_q;

  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [32:0] diff;
  logic [64:0] dstep;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op1_mag = (SIGNED_DIV && OPDATA1[31]) ? (32'd0 - OPDATA1) : OPDATA1;
  assign op2_mag = (SIGNED_DIV && OPDATA2[31]) ? (32'd0 - OPDATA2) : OPDATA2;

  // Trial subtraction of the divisor from the already-shifted partial remainder.
  assign diff  = {1'b0, dreg[63:32]} - {1'b0, vreg};
  assign dstep = diff[32] ? {dreg, 1'b0} : {diff[31:0], dreg[31:0], 1'b1};

  assign quo_mag = dstep[31:0];
  assign rem_mag = dstep[64:33];

  // Truncating division: quotient sign from XOR of signs, remainder follows dividend.
  assign quo_fix = (signed_q && (sign1 ^ sign2)) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_fix = (signed_q && sign1) ? (32'd0 - rem_mag) : rem_mag;

  assign DIV_STALL_REQ = START & ~READY & ~ANNUL & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      dreg     <= 64'd0;
      vreg     <= 32'd0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      signed_q <= 1'b0;
      RESULT   <= 64'd0;
      READY    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START && !ANNUL) begin
            if (OPDATA2 == 32'd0) begin
              state <= S_BY_ZERO;
            end else begin
              state    <= S_ON;
              dreg     <= {31'd0, op1_mag, 1'b0};
              vreg     <= op2_mag;
              sign1    <= OPDATA1[31];
              sign2    <= OPDATA2[31];
              signed_q <= SIGNED_DIV;
              cnt      <= 5'd0;
            end
          end
        end

        S_BY_ZERO: begin
          state  <= S_END;
          READY  <= 1'b1;
          RESULT <= 64'd0;
        end

        S_ON: begin
          if (ANNUL) begin
            state <= S_IDLE;
          end else begin
            dreg <= dstep[63:0];
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state  <= S_END;
              READY  <= 1'b1;
              RESULT <= {rem_fix, quo_fix};
            end
          end
        end

        S_END: begin
          // Result is held for as long as EX keeps START asserted.
          if (ANNUL || !START) begin
            state  <= S_IDLE;
            READY  <= 1'b0;
            RESULT <= 64'd0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit

module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ANNUL;
  logic        SIGNED_DIV;
  logic [31:0] OPDATA1;
  logic [31:0] OPDATA2;
  logic [63:0] RESULT;
  logic        READY;
  logic        DIV_STALL_REQ;

  int vectors;
  int miscompares;

  div_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .ANNUL         (ANNUL),
    .SIGNED_DIV    (SIGNED_DIV),
    .OPDATA1       (OPDATA1),
    .OPDATA2       (OPDATA2),
    .RESULT        (RESULT),
    .READY         (READY),
    .DIV_STALL_REQ (DIV_STALL_REQ)
  );

  always #5 CLK = ~CLK;

  // Reference: truncating integer division in 64-bit arithmetic; x/0 yields 0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called just after a rising edge in IDLE; that cycle becomes cycle 0.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls, output logic [63:0] res,
                        output logic rdy_after, output logic [63:0] res_after);
    lat = -1;
    stalls = 0;
    res = 64'd0;
    START = 1'b1;
    ANNUL = 1'b0;
    SIGNED_DIV = sgn;
    OPDATA1 = a;
    OPDATA2 = b;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (DIV_STALL_REQ) stalls++;
      if (READY) begin
        lat = k;
        res = RESULT;
        break;
      end
      tick();
      // Operands must have been captured on entry; scramble them afterwards.
      OPDATA1 = $urandom;
      OPDATA2 = $urandom;
    end
    START = 1'b0;
    tick();
    rdy_after = READY;
    res_after = RESULT;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    START = 1'b1;
    ANNUL = 1'b0;
    SIGNED_DIV = 1'b0;
    OPDATA1 = 32'd100;
    OPDATA2 = 32'd7;
    tick();
    #1;
    vectors++;
    if (DIV_STALL_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b want 0", DIV_STALL_REQ);
    end
    vectors++;
    if (READY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", READY);
    end
    vectors++;
    if (RESULT !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %h want 0", RESULT);
    end
    START = 1'b0;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_divu_100_7();
    int lat, stalls;
    logic [63:0] res, res_after;
    logic rdy_after;
    do_div(1'b0, 32'd100, 32'd7, lat, stalls, res, rdy_after, res_after);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL divu_latency: got %0d want 33", lat);
    end
    vectors++;
    if (res !== {32'd2, 32'd14}) begin
      miscompares++;
      $display("FAIL divu_result: got %h want %h", res, {32'd2, 32'd14});
    end
    vectors++;
    if (stalls !== 33) begin
      miscompares++;
      $display("FAIL divu_stall_cycles: got %0d want 33", stalls);
    end
    vectors++;
    if (rdy_after !== 1'b0 || res_after !== 64'd0) begin
      miscompares++;
      $display("FAIL divu_release: ready %b result %h want 0/0", rdy_after, res_after);
    end
  endtask

  task automatic test_signed_corners();
    logic [31:0] a_tab  [3] = '{32'hFFFFFFF9, 32'd7,        32'h80000000};
    logic [31:0] b_tab  [3] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] lo_tab [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
    logic [31:0] hi_tab [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    int lat, stalls;
    logic [63:0] res, res_after;
    logic rdy_after;
    for (int i = 0; i < 3; i++) begin
      do_div(1'b1, a_tab[i], b_tab[i], lat, stalls, res, rdy_after, res_after);
      vectors++;
      if (res !== {hi_tab[i], lo_tab[i]}) begin
        miscompares++;
        $display("FAIL signed_corner_%0d: got %h want %h", i, res, {hi_tab[i], lo_tab[i]});
      end
      vectors++;
      if (lat !== 33) begin
        miscompares++;
        $display("FAIL signed_corner_%0d_latency: got %0d want 33", i, lat);
      end
    end
  endtask

  task automatic test_by_zero();
    int lat, stalls;
    logic [63:0] res, res_after;
    logic rdy_after;
    for (int s = 0; s < 2; s++) begin
      do_div(s[0], 32'd5, 32'd0, lat, stalls, res, rdy_after, res_after);
      vectors++;
      if (lat !== 2) begin
        miscompares++;
        $display("FAIL by_zero_latency_%0d: got %0d want 2", s, lat);
      end
      vectors++;
      if (res !== 64'd0) begin
        miscompares++;
        $display("FAIL by_zero_result_%0d: got %h want 0", s, res);
      end
      vectors++;
      if (stalls !== 2) begin
        miscompares++;
        $display("FAIL by_zero_stall_%0d: got %0d want 2", s, stalls);
      end
    end
  endtask

  task automatic test_random();
    int lat, stalls, want_lat, mode;
    logic [63:0] res, res_after, want;
    logic rdy_after, sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 5);
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (mode == 2) b = $urandom_range(1, 15);
      else if (mode == 3) b = b | 32'h80000000;
      want = ref_div(sgn, a, b);
      want_lat = (b == 32'd0) ? 2 : 33;
      do_div(sgn, a, b, lat, stalls, res, rdy_after, res_after);
      vectors++;
      if (res !== want) begin
        miscompares++;
        $display("FAIL random_%0d_result: s=%b a=%h b=%h got %h want %h", i, sgn, a, b, res, want);
      end
      vectors++;
      if (lat !== want_lat || stalls !== want_lat) begin
        miscompares++;
        $display("FAIL random_%0d_timing: lat %0d stalls %0d want %0d", i, lat, stalls, want_lat);
      end
      vectors++;
      if (rdy_after !== 1'b0 || res_after !== 64'd0) begin
        miscompares++;
        $display("FAIL random_%0d_release: ready %b result %h want 0/0", i, rdy_after, res_after);
      end
    end
  endtask

  task automatic test_hold_end();
    logic [63:0] want;
    int k;
    want = ref_div(1'b0, 32'd1000, 32'd33);
    START = 1'b1;
    ANNUL = 1'b0;
    SIGNED_DIV = 1'b0;
    OPDATA1 = 32'd1000;
    OPDATA2 = 32'd33;
    for (k = 0; k < 60; k++) begin
      #1;
      if (READY) break;
      tick();
    end
    vectors++;
    if (k !== 33) begin
      miscompares++;
      $display("FAIL hold_latency: got %0d want 33", k);
    end
    for (int h = 0; h < 3; h++) begin
      tick();
      #1;
      vectors++;
      if (READY !== 1'b1 || RESULT !== want || DIV_STALL_REQ !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_end_%0d: ready %b result %h stall %b want 1/%h/0", h, READY, RESULT, DIV_STALL_REQ, want);
      end
    end
    START = 1'b0;
    tick();
    vectors++;
    if (READY !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got %b want 0", READY);
    end
  endtask

  task automatic test_annul();
    int lat, stalls;
    logic [63:0] res, res_after;
    logic rdy_after, seen;
    seen = 1'b0;
    // START together with ANNUL in IDLE is refused.
    START = 1'b1;
    ANNUL = 1'b1;
    OPDATA1 = 32'd5;
    OPDATA2 = 32'd0;
    #1;
    vectors++;
    if (DIV_STALL_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_idle_stall: got %b want 0", DIV_STALL_REQ);
    end
    tick();
    START = 1'b0;
    ANNUL = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (READY) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_idle_ready: got %b want 0", seen);
    end
    // ANNUL in cycle 10 of a running division.
    START = 1'b1;
    SIGNED_DIV = 1'b0;
    OPDATA1 = $urandom;
    OPDATA2 = $urandom | 32'd1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (READY) seen = 1'b1;
      tick();
    end
    ANNUL = 1'b1;
    #1;
    vectors++;
    if (DIV_STALL_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_stall: got %b want 0", DIV_STALL_REQ);
    end
    tick();
    ANNUL = 1'b0;
    vectors++;
    if (READY !== 1'b0 || seen !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_ready: ready %b seen %b want 0/0", READY, seen);
    end
    do_div(1'b0, 32'd9, 32'd3, lat, stalls, res, rdy_after, res_after);
    vectors++;
    if (lat !== 33 || res !== {32'd0, 32'd3}) begin
      miscompares++;
      $display("FAIL annul_followup: lat %0d result %h want 33/%h", lat, res, {32'd0, 32'd3});
    end
  endtask

  task automatic test_rst_mid();
    logic seen;
    seen = 1'b0;
    START = 1'b1;
    ANNUL = 1'b0;
    SIGNED_DIV = 1'b1;
    OPDATA1 = $urandom;
    OPDATA2 = $urandom | 32'd1;
    for (int k = 0; k < 15; k++) tick();
    RST = 1'b1;
    #1;
    vectors++;
    if (DIV_STALL_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_stall: got %b want 0", DIV_STALL_REQ);
    end
    tick();
    RST = 1'b0;
    START = 1'b0;
    #1;
    vectors++;
    if (READY !== 1'b0 || RESULT !== 64'd0 || DIV_STALL_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: ready %b result %h stall %b want 0", READY, RESULT, DIV_STALL_REQ);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (READY) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_ready: got %b want 0", seen);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_divu_100_7();
    test_signed_corners();
    test_by_zero();
    test_hold_end();
    test_annul();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
